// File: rtl/data_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_router_pkg
// Description : Shared FSM state encoding and request decode for the
//               multi-channel data router with bit read-modify-write.
// Revision    : 1.0  initial release
// ============================================================================
package data_router_pkg;

    // Router FSM states; 3 bits covers the six states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_BWR     = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Operation kind, encoded as {bit_mode, we} so decode is a plain concat.
    typedef enum logic [1:0] {
        OP_WORD_RD = 2'b00,
        OP_WORD_WR = 2'b01,
        OP_BIT_RD  = 2'b10,
        OP_BIT_WR  = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic we, input logic bit_mode);
        return op_e'({bit_mode, we});
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The first requester at or
//               after the pointer (wrapping) receives a one-hot grant.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int  NUM_CH = 2,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [PTR_W-1:0]  o_gnt_idx,
    output logic              o_gnt_valid
);

    int scan_ch;

    // Scan from the farthest offset down to the pointer so the nearest requester wins.
    always_comb begin
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        scan_ch     = 0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            scan_ch = (int'(i_ptr) + off) % NUM_CH;
            if (i_req[scan_ch]) begin
                o_gnt          = '0;
                o_gnt[scan_ch] = 1'b1;
                o_gnt_idx      = PTR_W'(scan_ch);
                o_gnt_valid    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_router_rmw.sv
`default_nettype none
// ============================================================================
// Module      : data_router_rmw
// Description : Round-robin router of NUM_CH core requests onto one
//               synchronous RAM port. Word read/write, bit read and atomic
//               bit write (read-modify-write). All outputs are registered.
// Revision    : 1.0  initial release
// ============================================================================
module data_router_rmw
    import data_router_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  ADDR_W = 8,
    parameter int  NUM_CH = 2,
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH-1:0]        REQ,
    input  logic [NUM_CH-1:0]        WE,
    input  logic [NUM_CH-1:0]        BIT_MODE,
    input  logic [NUM_CH*ADDR_W-1:0] ADDR,
    input  logic [NUM_CH*DATA_W-1:0] WDATA,
    input  logic [NUM_CH-1:0]        WBIT,
    input  logic [NUM_CH*IDX_W-1:0]  BIT_IDX,
    output logic [NUM_CH-1:0]        ACK,
    output logic [DATA_W-1:0]        RDATA,
    output logic                     BUSY,
    output logic [ADDR_W-1:0]        RAM_ADDR,
    output logic                     RAM_WE,
    output logic [DATA_W-1:0]        RAM_WDATA,
    input  logic [DATA_W-1:0]        RAM_RDATA
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Bit extract; indices past the word width read as zero.
    function automatic logic get_bit(input logic [DATA_W-1:0] word, input logic [IDX_W-1:0] idx);
        logic res;
        res = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(idx) == i) res = word[i];
        end
        return res;
    endfunction

    // Bit insert; indices past the word width leave the word untouched.
    function automatic logic [DATA_W-1:0] put_bit(input logic [DATA_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx,
                                                   input logic              val);
        logic [DATA_W-1:0] res;
        res = word;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(idx) == i) res[i] = val;
        end
        return res;
    endfunction

    // Arbiter
    logic [NUM_CH-1:0] w_gnt;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_gnt_valid;

    // Granted channel's request fields
    logic              w_sel_we;
    logic              w_sel_bm;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_wbit;
    logic [IDX_W-1:0]  w_sel_idx;

    // State and latched request
    state_e            state_q,     state_d;
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic [NUM_CH-1:0] gnt_q,       gnt_d;
    logic [PTR_W-1:0]  gnt_idx_q,   gnt_idx_d;
    op_e               op_q,        op_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              wbit_q,      wbit_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;

    // Registered outputs
    logic [NUM_CH-1:0] ack_q,       ack_d;
    logic [DATA_W-1:0] rdata_out_q, rdata_out_d;
    logic              busy_q,      busy_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_we_q,    ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req       (REQ),
        .i_ptr       (ptr_q),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    // Mux out the granted channel's request fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_bm    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wbit  = 1'b0;
        w_sel_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == int'(w_gnt_idx)) begin
                w_sel_we    = WE[k];
                w_sel_bm    = BIT_MODE[k];
                w_sel_addr  = ADDR[k*ADDR_W +: ADDR_W];
                w_sel_wdata = WDATA[k*DATA_W +: DATA_W];
                w_sel_wbit  = WBIT[k];
                w_sel_idx   = BIT_IDX[k*IDX_W +: IDX_W];
            end
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wbit_d      = wbit_q;
        idx_d       = idx_q;
        ack_d       = '0;
        rdata_out_d = '0;
        ram_we_d    = 1'b0;
        ram_wdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    gnt_d     = w_gnt;
                    gnt_idx_d = w_gnt_idx;
                    op_d      = decode_op(w_sel_we, w_sel_bm);
                    addr_d    = w_sel_addr;
                    wdata_d   = w_sel_wdata;
                    wbit_d    = w_sel_wbit;
                    idx_d     = w_sel_idx;
                    if (decode_op(w_sel_we, w_sel_bm) == OP_WORD_WR) begin
                        state_d     = ST_WR;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = w_sel_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
                ack_d   = gnt_q;
            end
            ST_RD: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // RAM_RDATA is valid now; it feeds the write-back or the read result directly.
                if (op_q == OP_BIT_WR) begin
                    state_d     = ST_BWR;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = put_bit(RAM_RDATA, idx_q, wbit_q);
                end else begin
                    state_d = ST_DONE;
                    ack_d   = gnt_q;
                    if (op_q == OP_WORD_RD) begin
                        rdata_out_d = RAM_RDATA;
                    end else begin
                        rdata_out_d = {{(DATA_W-1){1'b0}}, get_bit(RAM_RDATA, idx_q)};
                    end
                end
            end
            ST_BWR: begin
                state_d = ST_DONE;
                ack_d   = gnt_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = (int'(gnt_idx_q) == NUM_CH - 1) ? '0 : gnt_idx_q + PTR_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        ram_addr_d = (state_d != ST_IDLE) ? addr_d : '0;
    end

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            op_q        <= OP_WORD_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            wbit_q      <= 1'b0;
            idx_q       <= '0;
            ack_q       <= '0;
            rdata_out_q <= '0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wbit_q      <= wbit_d;
            idx_q       <= idx_d;
            ack_q       <= ack_d;
            rdata_out_q <= rdata_out_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ACK       = ack_q;
    assign RDATA     = rdata_out_q;
    assign BUSY      = busy_q;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_WE    = ram_we_q;
    assign RAM_WDATA = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_router_rmw.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_router_rmw
// Description : Directed self-checking bench for data_router_rmw. Instance A
//               is the default 8-bit build, instance B a 6-bit data build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_router_rmw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic init;
    logic sel;

    // Instance A (DATA_W=8)
    logic [1:0]  reqA, weA, bmA, wbitA, ackA;
    logic [15:0] addrA, wdA;
    logic [5:0]  idxA;
    logic [7:0]  rdA, raddrA, rwdA, rrdA;
    logic        busyA, rweA;

    // Instance B (DATA_W=6)
    logic [1:0]  reqB, weB, bmB, wbitB, ackB;
    logic [15:0] addrB;
    logic [11:0] wdB;
    logic [5:0]  idxB;
    logic [5:0]  rdB, rwdB, rrdB;
    logic [7:0]  raddrB;
    logic        busyB, rweB;

    data_router_rmw #(.DATA_W(8), .ADDR_W(8), .NUM_CH(2)) dut_a (
        .CLK(clk), .RST(rst), .REQ(reqA), .WE(weA), .BIT_MODE(bmA),
        .ADDR(addrA), .WDATA(wdA), .WBIT(wbitA), .BIT_IDX(idxA),
        .ACK(ackA), .RDATA(rdA), .BUSY(busyA), .RAM_ADDR(raddrA),
        .RAM_WE(rweA), .RAM_WDATA(rwdA), .RAM_RDATA(rrdA)
    );

    data_router_rmw #(.DATA_W(6), .ADDR_W(8), .NUM_CH(2)) dut_b (
        .CLK(clk), .RST(rst), .REQ(reqB), .WE(weB), .BIT_MODE(bmB),
        .ADDR(addrB), .WDATA(wdB), .WBIT(wbitB), .BIT_IDX(idxB),
        .ACK(ackB), .RDATA(rdB), .BUSY(busyB), .RAM_ADDR(raddrB),
        .RAM_WE(rweB), .RAM_WDATA(rwdB), .RAM_RDATA(rrdB)
    );

    // Synchronous RAMs, read-first, one cycle read latency.
    logic [7:0] memA [256];
    logic [5:0] memB [256];
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) begin
                memA[i] <= '0;
                memB[i] <= '0;
            end
        end else begin
            if (rweA) memA[raddrA] <= rwdA;
            if (rweB) memB[raddrB] <= rwdB;
        end
        rrdA <= memA[raddrA];
        rrdB <= memB[raddrB];
    end

    // Selected-instance view
    logic [1:0] s_ack;
    logic [7:0] s_rd, s_wd, s_addr;
    logic       s_we, s_busy;
    assign s_ack  = sel ? ackB : ackA;
    assign s_rd   = sel ? {2'b00, rdB} : rdA;
    assign s_wd   = sel ? {2'b00, rwdB} : rwdA;
    assign s_addr = sel ? raddrB : raddrA;
    assign s_we   = sel ? rweB : rweA;
    assign s_busy = sel ? busyB : busyA;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic w, input logic b, input logic [7:0] a,
                          input logic [7:0] d, input logic wb, input logic [2:0] ix);
        if (!sel) begin
            weA[ch] = w; bmA[ch] = b; addrA[ch*8 +: 8] = a; wdA[ch*8 +: 8] = d;
            wbitA[ch] = wb; idxA[ch*3 +: 3] = ix;
        end else begin
            weB[ch] = w; bmB[ch] = b; addrB[ch*8 +: 8] = a; wdB[ch*6 +: 6] = d[5:0];
            wbitB[ch] = wb; idxB[ch*3 +: 3] = ix;
        end
    endtask

    // One transaction on the selected instance, raised while the router is idle.
    task automatic do_txn(input string tag, input int ch, input int exp_lat, input logic [7:0] exp_rd,
                          input int exp_wen, input int exp_we_at, input logic [7:0] exp_wd,
                          input logic [7:0] exp_wa);
        int n, wen, we_at;
        logic got;
        logic [7:0] wd, wa, rd_seen;
        logic [1:0] ack_seen, exp_ack;
        n = 0; wen = 0; we_at = -1; got = 1'b0; wd = '0; wa = '0; rd_seen = '0; ack_seen = '0;
        exp_ack = 2'(1 << ch);
        if (!sel) reqA[ch] = 1'b1; else reqB[ch] = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (s_we) begin
                wen++;
                if (we_at < 0) begin we_at = n; wd = s_wd; wa = s_addr; end
            end
            if (s_ack != 2'b00) begin
                got = 1'b1; ack_seen = s_ack; rd_seen = s_rd;
                reqA = '0; reqB = '0;
            end
        end
        reqA = '0; reqB = '0;
        check({tag, ".ack"},     32'(ack_seen), 32'(exp_ack));
        check({tag, ".latency"}, 32'(n),        32'(exp_lat));
        check({tag, ".rdata"},   32'(rd_seen),  32'(exp_rd));
        check({tag, ".we_cnt"},  32'(wen),      32'(exp_wen));
        if (exp_wen > 0) begin
            check({tag, ".we_cycle"}, 32'(we_at), 32'(exp_we_at));
            check({tag, ".wdata"},    32'(wd),    32'(exp_wd));
            check({tag, ".waddr"},    32'(wa),    32'(exp_wa));
        end
        @(negedge clk);
        check({tag, ".idle_busy"}, 32'(s_busy), 32'(0));
    endtask

    int         nacks, nwe, wen, acks;
    int         ack_n [3];
    logic [1:0] ack_v [3];
    logic [7:0] we_d  [3];

    initial begin
        rst = 1'b1; init = 1'b1; sel = 1'b0;
        reqA = '0; weA = '0; bmA = '0; wbitA = '0; addrA = '0; wdA = '0; idxA = '0;
        reqB = '0; weB = '0; bmB = '0; wbitB = '0; addrB = '0; wdB = '0; idxB = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.ack",   32'(ackA),   32'(0));
        check("rst.rdata", 32'(rdA),    32'(0));
        check("rst.busy",  32'(busyA),  32'(0));
        check("rst.ramwe", 32'(rweA),   32'(0));
        check("rst.raddr", 32'(raddrA), 32'(0));
        check("rst.rwd",   32'(rwdA),   32'(0));
        check("rst.ackB",  32'(ackB),   32'(0));
        rst = 1'b0; init = 1'b0;
        @(negedge clk);

        // Word write ch0 0x10 <= 0xA5
        set_ch(0, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 3'd0);
        do_txn("wwr", 0, 2, 8'h00, 1, 1, 8'hA5, 8'h10);
        check("mem10_a5", 32'(memA[8'h10]), 32'hA5);

        // Bit write ch1 0x10 bit3 <= 1 : 0xA5 -> 0xAD, write only in BWR
        set_ch(1, 1'b1, 1'b1, 8'h10, 8'h00, 1'b1, 3'd3);
        do_txn("bwr", 1, 4, 8'h00, 1, 3, 8'hAD, 8'h10);
        check("mem10_ad", 32'(memA[8'h10]), 32'hAD);

        // Bit read ch0 0x10 bit2 of 0xAD -> 1
        set_ch(0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 3'd2);
        do_txn("brd", 0, 3, 8'h01, 0, 0, 8'h00, 8'h00);

        // Word read ch0 0x10 -> 0xAD
        set_ch(0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 3'd0);
        do_txn("wrd", 0, 3, 8'hAD, 0, 0, 8'h00, 8'h00);

        // Reset during RD_WAIT of a ch1 bit write (would clear bit0 -> 0xAC)
        set_ch(1, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 3'd0);
        reqA[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("mid.busy", 32'(busyA), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mid.ack",   32'(ackA),   32'(0));
        check("mid.ramwe", 32'(rweA),   32'(0));
        check("mid.busy0", 32'(busyA),  32'(0));
        check("mid.rdata", 32'(rdA),    32'(0));
        check("mid.raddr", 32'(raddrA), 32'(0));
        check("mid.rwd",   32'(rwdA),   32'(0));
        rst = 1'b0; reqA = '0;
        wen = 0; acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (rweA) wen++;
            if (ackA != 2'b00) acks++;
        end
        check("mid.we_after",  32'(wen),  32'(0));
        check("mid.ack_after", 32'(acks), 32'(0));
        check("mid.mem10",     32'(memA[8'h10]), 32'hAD);

        // Both channels held: ch0 word write 0x80, ch1 RMW bit0<=1 at same address
        set_ch(0, 1'b1, 1'b0, 8'h21, 8'h80, 1'b0, 3'd0);
        set_ch(1, 1'b1, 1'b1, 8'h21, 8'h00, 1'b1, 3'd0);
        nacks = 0; nwe = 0;
        for (int i = 0; i < 3; i++) begin ack_n[i] = 0; ack_v[i] = '0; we_d[i] = '0; end
        reqA = 2'b11;
        for (int n = 1; n <= 30 && nacks < 3; n++) begin
            @(negedge clk);
            if (rweA) begin
                if (nwe < 3) we_d[nwe] = rwdA;
                nwe++;
            end
            if (ackA != 2'b00) begin
                ack_n[nacks] = n; ack_v[nacks] = ackA; nacks++;
                if (nacks == 3) reqA = '0;
            end
        end
        reqA = '0;
        check("rr.nacks",  32'(nacks),    32'(3));
        check("rr.ack0",   32'(ack_v[0]), 32'(2'b01));
        check("rr.ack1",   32'(ack_v[1]), 32'(2'b10));
        check("rr.ack2",   32'(ack_v[2]), 32'(2'b01));
        check("rr.ackn0",  32'(ack_n[0]), 32'(2));
        check("rr.ackn1",  32'(ack_n[1]), 32'(7));
        check("rr.ackn2",  32'(ack_n[2]), 32'(10));
        check("rr.nwe",    32'(nwe),      32'(3));
        check("rr.wd0",    32'(we_d[0]),  32'h80);
        check("rr.wd1",    32'(we_d[1]),  32'h81);
        check("rr.wd2",    32'(we_d[2]),  32'h80);
        @(negedge clk);
        check("rr.mem21",  32'(memA[8'h21]), 32'h80);

        // Narrow build: out-of-range bit index
        sel = 1'b1;
        @(negedge clk);
        set_ch(0, 1'b1, 1'b0, 8'h05, 8'h2A, 1'b0, 3'd0);
        do_txn("b.wwr", 0, 2, 8'h00, 1, 1, 8'h2A, 8'h05);
        set_ch(0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 3'd7);
        do_txn("b.bwr7", 0, 4, 8'h00, 1, 3, 8'h2A, 8'h05);
        check("b.mem05_2a", 32'(memB[8'h05]), 32'h2A);
        set_ch(0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 3'd7);
        do_txn("b.brd7", 0, 3, 8'h00, 0, 0, 8'h00, 8'h00);
        set_ch(0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 3'd5);
        do_txn("b.brd5", 0, 3, 8'h01, 0, 0, 8'h00, 8'h00);
        set_ch(0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 3'd0);
        do_txn("b.bwr0", 0, 4, 8'h00, 1, 3, 8'h2B, 8'h05);
        check("b.mem05_2b", 32'(memB[8'h05]), 32'h2B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
